useq_ctl: RTL and testbench



---
 rtl/useq_pkg.sv | 19 +
 rtl/ustack.sv | 52 +++++
 rtl/useq_ctl.sv | 145 ++++++++++++++
 tb/tb_useq_ctl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared opcode encoding and default geometry for the microsequencer next-address stage.
package useq_pkg;

    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 4;
    localparam int CW_DEF    = 8;

    typedef enum logic [2:0] {
        OP_CONT  = 3'b000,
        OP_JMP   = 3'b001,
        OP_BRC   = 3'b010,
        OP_CALL  = 3'b011,
        OP_RET   = 3'b100,
        OP_LDCNT = 3'b101,
        OP_LOOP  = 3'b110,
        OP_WAIT  = 3'b111
    } seq_op_t;

endpackage

// File: rtl/ustack.sv
// DEPTH x AW LIFO holding micro-subroutine return addresses; only the pointer is reset.
module ustack #(
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            din,
    output logic [AW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE      = (PW+1)'(1);

    logic [AW-1:0] mem [DEPTH];
    logic [PW:0]   sp;
    logic [PW:0]   top;
    logic          do_push;
    logic          do_pop;

    assign full    = (sp == FULL_LVL);
    assign empty   = (sp == '0);
    assign depth   = sp;
    assign top     = sp - ONE;
    // Top-of-stack is read combinationally so a RET right after a CALL sees the new entry.
    assign dout    = mem[top[PW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty & ~push;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + ONE;
        end else if (do_pop) begin
            sp <= sp - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[sp[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/useq_ctl.sv
// Microsequencer next-address stage: decodes seq_op each cycle and drives load_incr/upc_next
// into the uPC register, owning the return stack and the loop counter.
module useq_ctl
    import useq_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AW-1:0]            upc,
    input  logic [2:0]               seq_op,
    input  logic [AW-1:0]            target,
    input  logic [1:0]               cond_sel,
    input  logic                     cond_inv,
    input  logic [3:0]               flags,
    input  logic [CW-1:0]            cnt_imm,
    output logic                     load_incr,
    output logic [AW-1:0]            upc_next,
    output logic [$clog2(DEPTH):0]   sp_depth,
    output logic                     cnt_zero,
    output logic                     stk_ovf,
    output logic                     stk_unf
);

    seq_op_t       op;
    logic          cond;
    logic [AW-1:0] inc;

    logic          push;
    logic          pop;
    logic [AW-1:0] stk_dout;
    logic          stk_full;
    logic          stk_empty;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ovf_set;
    logic          unf_set;

    assign op       = seq_op_t'(seq_op);
    assign cond     = flags[cond_sel] ^ cond_inv;
    assign inc      = upc + AW'(1);
    assign cnt_zero = (cnt == '0);

    ustack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .depth (sp_depth)
    );

    // Next-address decode. During reset nothing is allowed to touch state and the
    // uPC is steered to address 0.
    always_comb begin
        load_incr = 1'b0;
        upc_next  = inc;
        push      = 1'b0;
        pop       = 1'b0;
        cnt_nxt   = cnt;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (reset) begin
            load_incr = 1'b1;
            upc_next  = '0;
        end else begin
            case (op)
                OP_CONT: begin
                end
                OP_JMP: begin
                    load_incr = 1'b1;
                    upc_next  = target;
                end
                OP_BRC: begin
                    if (cond) begin
                        load_incr = 1'b1;
                        upc_next  = target;
                    end
                end
                OP_CALL: begin
                    // A full stack drops the return address but the call still jumps.
                    push      = ~stk_full;
                    ovf_set   = stk_full;
                    load_incr = 1'b1;
                    upc_next  = target;
                end
                OP_RET: begin
                    load_incr = 1'b1;
                    if (stk_empty) begin
                        upc_next = '0;
                        unf_set  = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        upc_next = stk_dout;
                    end
                end
                OP_LDCNT: begin
                    cnt_nxt = cnt_imm;
                end
                OP_LOOP: begin
                    // Counter saturates at zero; exhausted loops fall through.
                    if (cnt != '0) begin
                        cnt_nxt   = cnt - CW'(1);
                        load_incr = 1'b1;
                        upc_next  = target;
                    end
                end
                OP_WAIT: begin
                    if (!cond) begin
                        load_incr = 1'b1;
                        upc_next  = upc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (ovf_set) begin
                stk_ovf <= 1'b1;
            end
            if (unf_set) begin
                stk_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_useq_ctl.sv
// Bench for useq_ctl: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_useq_ctl;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int W     = 12;

    logic          clk;
    logic          reset;
    logic [AW-1:0] upc;
    logic [2:0]    seq_op;
    logic [AW-1:0] target;
    logic [1:0]    cond_sel;
    logic          cond_inv;
    logic [3:0]    flags;
    logic [CW-1:0] cnt_imm;
    logic          load_incr;
    logic [AW-1:0] upc_next;
    logic [2:0]    sp_depth;
    logic          cnt_zero;
    logic          stk_ovf;
    logic          stk_unf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // Behavioural model state
    int m_stk[$];
    int m_cnt;
    bit m_ovf;
    bit m_unf;

    useq_ctl #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .upc       (upc),
        .seq_op    (seq_op),
        .target    (target),
        .cond_sel  (cond_sel),
        .cond_inv  (cond_inv),
        .flags     (flags),
        .cnt_imm   (cnt_imm),
        .load_incr (load_incr),
        .upc_next  (upc_next),
        .sp_depth  (sp_depth),
        .cnt_zero  (cnt_zero),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        reset = 1'b1; upc = '0; seq_op = '0; target = '0;
        cond_sel = '0; cond_inv = 1'b0; flags = '0; cnt_imm = '0;
        m_cnt = 0; m_ovf = 0; m_unf = 0;
    end

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: applies one cycle of inputs at the falling edge, records the model's
    // expected outputs for that cycle, then advances the model past the next rising edge.
    task automatic drive(input bit rst, input int op, input int pc, input int tg,
                         input int cs, input bit ci, input int fl, input int imm);
        logic [W-1:0] e;
        int  inc;
        int  nx;
        bit  li;
        bit  c;
        int  sd;
        bit  cz;
        bit  ov;
        bit  un;
        @(negedge clk);
        reset    = rst;
        seq_op   = 3'(op);
        upc      = AW'(pc);
        target   = AW'(tg);
        cond_sel = 2'(cs);
        cond_inv = ci;
        flags    = 4'(fl);
        cnt_imm  = CW'(imm);
        sd = m_stk.size();
        cz = (m_cnt == 0);
        ov = m_ovf;
        un = m_unf;
        c   = ((fl >> cs) & 1) != ci;
        inc = (pc + 1) % 32;
        li  = 0;
        nx  = inc;
        if (rst) begin
            li = 1; nx = 0;
            m_stk.delete();
            m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            case (op)
                1: begin li = 1; nx = tg; end
                2: if (c) begin li = 1; nx = tg; end
                3: begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(inc);
                    else m_ovf = 1;
                    li = 1; nx = tg;
                end
                4: begin
                    li = 1;
                    if (m_stk.size() == 0) begin nx = 0; m_unf = 1; end
                    else nx = m_stk.pop_back();
                end
                5: m_cnt = imm;
                6: if (m_cnt != 0) begin m_cnt = m_cnt - 1; li = 1; nx = tg; end
                7: if (!c) begin li = 1; nx = pc; end
                default: ;
            endcase
        end
        e = {li, 5'(nx), 3'(sd), cz, ov, un};
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int op, input int pc, input int tg);
        drive(0, op, pc, tg, 0, 0, 0, 0);
    endtask

    // Scoreboard compare process
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {load_incr, upc_next, sp_depth, cnt_zero, stk_ovf, stk_unf};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got %03h expected %03h (li,nx,sp,cz,ovf,unf)",
                             $time, a, e);
                end
            end
        end
    end

    initial begin
        #1;
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        #3; lit("reset_li", load_incr, 1); lit("reset_nx", upc_next, 0);

        cyc(0, 5, 0);
        #3; lit("cont_li", load_incr, 0); lit("cont_nx", upc_next, 6);
        lit("rst_sp", sp_depth, 0); lit("rst_cz", cnt_zero, 1);
        lit("rst_ovf", stk_ovf, 0); lit("rst_unf", stk_unf, 0);
        cyc(0, 31, 0);
        #3; lit("cont_wrap", upc_next, 0);

        drive(0, 2, 2, 9, 2, 0, 4, 0);
        #3; lit("brc_t_li", load_incr, 1); lit("brc_t_nx", upc_next, 9);
        drive(0, 2, 2, 9, 2, 1, 4, 0);
        #3; lit("brc_f_li", load_incr, 0); lit("brc_f_nx", upc_next, 3);

        cyc(3, 3, 20);
        #3; lit("call_nx", upc_next, 20);
        cyc(4, 22, 0);
        #3; lit("ret_nx", upc_next, 4); lit("ret_sp", sp_depth, 1);
        cyc(0, 4, 0);
        #3; lit("ret_sp0", sp_depth, 0);

        for (int i = 1; i <= 4; i++) cyc(3, i, 10);
        for (int i = 0; i < 4; i++) begin
            cyc(4, 0, 0);
            #3; lit("nest_ret", upc_next, 5 - i);
        end

        for (int i = 0; i < 5; i++) cyc(3, 10 + i, 7);
        #3; lit("ovf_jump", upc_next, 7); lit("ovf_sp", sp_depth, 4);
        for (int i = 0; i < 5; i++) begin
            cyc(4, 0, 0);
            #3;
            if (i == 0) lit("ovf_set", stk_ovf, 1);
            if (i < 4) lit("ovf_ret", upc_next, 14 - i);
            else begin lit("unf_nx", upc_next, 0); lit("unf_li", load_incr, 1); end
        end
        cyc(0, 0, 0);
        #3; lit("unf_set", stk_unf, 1); lit("ovf_sticky", stk_ovf, 1);

        drive(0, 5, 0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            cyc(6, 8, 10);
            #3;
            if (i == 0) lit("loop_cz0", cnt_zero, 0);
            lit("loop_nx", upc_next, (i < 3) ? 10 : 9);
            lit("loop_li", load_incr, (i < 3) ? 1 : 0);
        end
        cyc(0, 0, 0);
        #3; lit("loop_cz1", cnt_zero, 1);

        drive(0, 5, 0, 0, 0, 0, 0, 3);
        cyc(6, 8, 10);
        cyc(3, 11, 2);
        drive(1, 6, 8, 10, 0, 0, 0, 0);
        cyc(0, 0, 0);
        #3; lit("mid_rst_cz", cnt_zero, 1); lit("mid_rst_sp", sp_depth, 0);
        lit("mid_rst_ovf", stk_ovf, 0); lit("mid_rst_unf", stk_unf, 0);

        for (int i = 0; i < 4; i++) begin
            drive(0, 7, 17, 0, 0, 0, 0, 0);
            #3; lit("wait_hold", upc_next, 17); lit("wait_li", load_incr, 1);
        end
        drive(0, 7, 17, 0, 0, 0, 1, 0);
        #3; lit("wait_go", upc_next, 18);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 7), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15), $urandom_range(0, 6));
        end

        @(negedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
